// File: rtl/fetch_inst_queue.sv
// Decoupling queue between IF and ID: a small circular FIFO of {pc, inst} words
// that lets IF keep fetching while ID stalls, and drops everything on a redirect.
module fetch_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_to_ds_valid,
  input  logic [BUS_WD-1:0]          fs_to_ds_bus,
  output logic                       fq_allow_in,
  input  logic                       flush,
  input  logic                       ds_allow_in,
  output logic                       fq_to_ds_valid,
  output logic [BUS_WD-1:0]          fq_to_ds_bus,
  output logic [$clog2(DEPTH):0]     fq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a word moves on an edge where the producer's valid and the
  // consumer's allow are both high and flush is low; flush discards both sides.
  logic [BUS_WD-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;

  // allow depends only on registered count, so a full queue cannot take a
  // push in the same cycle as a pop.
  assign fq_allow_in    = (count != CW'(DEPTH));
  assign fq_to_ds_valid = (count != '0);
  assign fq_to_ds_bus   = fq_to_ds_valid ? mem[rd_ptr] : '0;
  assign fq_count       = count;

  assign push = fs_to_ds_valid && fq_allow_in && !flush;
  assign pop  = fq_to_ds_valid && ds_allow_in && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left uncleared; reset and flush only gate push.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= fs_to_ds_bus;
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed and randomized checks of fetch_inst_queue against a queue model.
module tb_fetch_inst_queue;

  localparam int DEPTH  = 4;
  localparam int BUS_WD = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              fs_to_ds_valid;
  logic [BUS_WD-1:0] fs_to_ds_bus;
  logic              fq_allow_in;
  logic              flush;
  logic              ds_allow_in;
  logic              fq_to_ds_valid;
  logic [BUS_WD-1:0] fq_to_ds_bus;
  logic [2:0]        fq_count;

  int checks = 0;
  int errors = 0;
  logic [BUS_WD-1:0] exp_q[$];

  fetch_inst_queue #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .fq_allow_in    (fq_allow_in),
    .flush          (flush),
    .ds_allow_in    (ds_allow_in),
    .fq_to_ds_valid (fq_to_ds_valid),
    .fq_to_ds_bus   (fq_to_ds_bus),
    .fq_count       (fq_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word(input logic [31:0] pc, input logic [31:0] inst);
    return {pc, inst};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(fq_to_ds_valid), 64'd0);
    chk({tag, "_bus"},   fq_to_ds_bus,        64'd0);
    chk({tag, "_count"}, 64'(fq_count),       64'd0);
    chk({tag, "_allow"}, 64'(fq_allow_in),    64'd1);
  endtask

  initial begin
    logic       do_push;
    logic       do_pop;
    logic [63:0] head;

    // Reset, with a push presented during reset that must be ignored.
    reset = 1'b1; flush = 1'b0; ds_allow_in = 1'b0;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = 64'hdead_beef_0000_0001;
    step(); step();
    reset = 1'b0; fs_to_ds_valid = 1'b0;
    chk_reset_vals("reset");

    // Fill with ID stalled.
    for (int i = 0; i < 4; i++) begin
      chk("fill_allow", 64'(fq_allow_in), 64'd1);
      fs_to_ds_valid = 1'b1;
      fs_to_ds_bus = word(32'h1c000000 + 32'(4 * i), 32'h11 + 32'(i));
      step();
      chk("fill_count", 64'(fq_count), 64'(i + 1));
    end
    fs_to_ds_valid = 1'b0;
    chk("full_allow", 64'(fq_allow_in), 64'd0);
    chk("full_head", fq_to_ds_bus, 64'h1c000000_00000011);

    // Drain in order.
    ds_allow_in = 1'b1;
    chk("drain0", fq_to_ds_bus, 64'h1c000000_00000011); step();
    chk("drain1", fq_to_ds_bus, 64'h1c000004_00000012); step();
    chk("drain2", fq_to_ds_bus, 64'h1c000008_00000013); step();
    chk("drain3", fq_to_ds_bus, 64'h1c00000c_00000014);
    chk("drain3_valid", 64'(fq_to_ds_valid), 64'd1);
    step();
    chk("drained_valid", 64'(fq_to_ds_valid), 64'd0);
    chk("drained_count", 64'(fq_count), 64'd0);
    chk("drained_bus", fq_to_ds_bus, 64'd0);

    // Empty queue: a fresh push is not visible in the same cycle.
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = word(32'h1c000020, 32'h20);
    chk("no_bypass_valid", 64'(fq_to_ds_valid), 64'd0);
    step();
    exp_q.push_back(64'h1c000020_00000020);

    // Streaming: push and pop every cycle, count held at 1.
    for (int i = 0; i < 20; i++) begin
      fs_to_ds_bus = word(32'h1c000024 + 32'(4 * i), 32'h21 + 32'(i));
      chk("stream_head", fq_to_ds_bus, exp_q.pop_front());
      exp_q.push_back(fs_to_ds_bus);
      step();
      chk("stream_count", 64'(fq_count), 64'd1);
    end
    fs_to_ds_valid = 1'b0;
    chk("stream_last", fq_to_ds_bus, 64'h1c000070_00000034);
    step();
    chk("stream_empty", 64'(fq_count), 64'd0);
    void'(exp_q.pop_front());

    // Full + pop: the presented push is refused that cycle.
    ds_allow_in = 1'b0; fs_to_ds_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fs_to_ds_bus = word(32'h1c000080 + 32'(4 * i), 32'h40 + 32'(i));
      step();
    end
    chk("fp_count4", 64'(fq_count), 64'd4);
    fs_to_ds_bus = word(32'h1c000090, 32'h44);
    ds_allow_in = 1'b1;
    chk("fp_allow0", 64'(fq_allow_in), 64'd0);
    step();
    chk("fp_count3", 64'(fq_count), 64'd3);
    chk("fp_head", fq_to_ds_bus, 64'h1c000084_00000041);
    chk("fp_allow1", 64'(fq_allow_in), 64'd1);
    ds_allow_in = 1'b0;
    step();
    chk("fp_count4b", 64'(fq_count), 64'd4);
    fs_to_ds_valid = 1'b0;

    // Reduce to 3 then flush with a push and a pop both offered.
    ds_allow_in = 1'b1;
    step();
    chk("pre_flush_count", 64'(fq_count), 64'd3);
    flush = 1'b1; fs_to_ds_valid = 1'b1; fs_to_ds_bus = word(32'h1c0000f0, 32'h77);
    step();
    flush = 1'b0; fs_to_ds_valid = 1'b0; ds_allow_in = 1'b0;
    chk_reset_vals("flush");
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = word(32'h1c000100, 32'h99);
    step();
    chk("post_flush_head", fq_to_ds_bus, 64'h1c000100_00000099);
    chk("post_flush_count", 64'(fq_count), 64'd1);

    // Reset mid-stream with count = 2.
    fs_to_ds_bus = word(32'h1c000104, 32'h9a);
    step();
    fs_to_ds_valid = 1'b0;
    chk("pre_reset_count", 64'(fq_count), 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("mid_reset");
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = word(32'h1c000200, 32'h55);
    step();
    fs_to_ds_valid = 1'b0;
    chk("post_reset_head", fq_to_ds_bus, 64'h1c000200_00000055);
    chk("post_reset_count", 64'(fq_count), 64'd1);
    ds_allow_in = 1'b1;
    step();
    chk("post_reset_empty", 64'(fq_count), 64'd0);

    // Random traffic against the scoreboard.
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      fs_to_ds_valid = ($urandom_range(0, 3) != 0);
      ds_allow_in    = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 63) == 0);
      fs_to_ds_bus   = {$urandom(), $urandom()};
      head = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
      chk("rnd_count", 64'(fq_count), 64'(exp_q.size()));
      chk("rnd_valid", 64'(fq_to_ds_valid), 64'(exp_q.size() != 0));
      chk("rnd_allow", 64'(fq_allow_in), 64'(exp_q.size() != DEPTH));
      chk("rnd_head", fq_to_ds_bus, head);
      do_push = fs_to_ds_valid && (exp_q.size() != DEPTH) && !flush;
      do_pop  = (exp_q.size() != 0) && ds_allow_in && !flush;
      if (flush) exp_q.delete();
      else begin
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(fs_to_ds_bus);
      end
      step();
    end
    flush = 1'b0; fs_to_ds_valid = 1'b0; ds_allow_in = 1'b0;
    chk("rnd_final_count", 64'(fq_count), 64'(exp_q.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Decoupling instruction queue between IF_stage and ID_stage. Accepts `{pc, inst}` words from IF under the valid/allow_in handshake, stores them in a small circular FIFO, and presents the oldest entry to ID. Lets IF keep fetching while ID stalls, and drops all queued instructions on a branch redirect.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `BUS_WD`, default 64: width of one entry, `{pc[31:0], inst[31:0]}`; equals `FS_TO_DS_WD`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fs_to_ds_valid`  in  1  IF has a valid entry on `fs_to_ds_bus`.
- `fs_to_ds_bus`  in  BUS_WD  entry from IF, `{pc, inst}`.
- `fq_allow_in`  out  1  queue accepts a push this cycle; drives IF's `ds_allow_in`.
- `flush`  in  1  branch redirect: discard all queued entries and this cycle's input.
- `ds_allow_in`  in  1  ID accepts the head entry this cycle.
- `fq_to_ds_valid`  out  1  head entry valid.
- `fq_to_ds_bus`  out  BUS_WD  head entry, oldest first.
- `fq_count`  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- State: `DEPTH` × `BUS_WD` storage, `wr_ptr` and `rd_ptr` (clog2(DEPTH) bits each, wrap modulo DEPTH), `count` (clog2(DEPTH)+1 bits).
- push = `fs_to_ds_valid && fq_allow_in && !flush`.
- pop = `fq_to_ds_valid && ds_allow_in && !flush`.
- `fq_allow_in = (count != DEPTH)`. It depends only on registered state, with no combinational path from `ds_allow_in`. A full queue does not accept a push in the same cycle as a pop.
- `fq_to_ds_valid = (count != 0)`.
- `fq_to_ds_bus = mem[rd_ptr]` when count ≠ 0, otherwise all zeros.
- On push: write `mem[wr_ptr]` and increment `wr_ptr`.
- On pop: increment `rd_ptr`.
- Count update: push only → count+1; pop only → count−1; push and pop together → count unchanged, both pointers advance.
- Pointers wrap from DEPTH−1 to 0 with no special casing.
- Flush: `wr_ptr`, `rd_ptr` and `count` are cleared to 0 at the next edge. The input word that cycle is discarded. Flush overrides push and pop.
  - Storage contents are not cleared and are don't-care.
  - ID must not consume the head in a flush cycle. Flush has priority: the head is dropped even if `ds_allow_in` = 1.
- Entries leave strictly in arrival order. No entry is duplicated or lost except by flush.
- No per-entry decode or modification; `pc` and `inst` pass through bit-exact.

## Timing
- Reset (synchronous, while `reset` = 1 at an edge):
  - Pointers and count are set to 0.
  - After the edge: `fq_to_ds_valid` = 0, `fq_to_ds_bus` = 0, `fq_count` = 0, `fq_allow_in` = 1.
  - Pushes presented in the reset cycle are ignored.
- Latency: an entry pushed at edge N appears on `fq_to_ds_bus` with `fq_to_ds_valid` = 1 in the cycle after edge N. There is no same-cycle bypass, so an empty queue never pops in the cycle it is written.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full (count = DEPTH):
  - `fq_allow_in` = 0 and IF holds.
  - A pop at edge N makes `fq_allow_in` = 1 in the following cycle.
- Empty (count = 0): `fq_to_ds_valid` = 0 and a pop is impossible.
- Flush at edge N: in the next cycle count = 0, `fq_to_ds_valid` = 0 and `fq_allow_in` = 1. The first post-redirect entry can be pushed in that same cycle.
- Reset asserted mid-operation: identical to flush, plus outputs take their reset values.
- Flush and reset in the same cycle: reset result, which is identical.

## Test plan
- Fill/drain: after reset, hold `ds_allow_in` = 0 and push pc 0x1c000000..0x1c00000c with inst 0x11..0x14.
  - `fq_allow_in` drops to 0 after the 4th push and `fq_count` = 4.
  - Then set `ds_allow_in` = 1: outputs appear in order, one per cycle, and valid falls after the 4th.
- Streaming: continuous push and pop for 20 cycles with DEPTH = 4, so pointers wrap 5×. Count stays at 1 and the output sequence equals the input sequence.
- Full + pop: with count = 4, pop while presenting a new push.
  - That push is not accepted and count = 3.
  - Next cycle `fq_allow_in` = 1 and the push is accepted, giving count = 4.
- Flush: with count = 3, assert flush together with a valid push and `ds_allow_in` = 1.
  - Next cycle count = 0, valid = 0, bus = 0, and no entry is consumed.
  - Push of pc 0x1c000100 then appears first.
- Reset mid-stream: with count = 2, assert reset for 1 cycle. Outputs take reset values and the queue accepts pushes immediately after.
- Random: random valid, `ds_allow_in` and rare flush for 10k cycles against a scoreboard FIFO model. Check ordering, no loss or duplication, and that `fq_count` always matches the model.
